// File: rtl/count_pkg.sv
// Shared definitions for the bounded event counter pair (up-counter and drain).
package count_pkg;

    // Largest legal count, shared with the up-counter
    localparam int unsigned COUNT_LIMIT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } count_state_t;

    // Saturate a requested count to the legal maximum
    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/count_drain.sv
// Consumer end of the bounded event counter: accepts a count over a load
// handshake and replays it as that many single tokens, counting down.
module count_drain
    import count_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = COUNT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_count,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [WIDTH:0]   remaining,
    output logic             busy,
    output logic             done,
    output logic             err
);

    count_state_t   r_state;
    count_state_t   w_state_next;
    logic [WIDTH:0] r_remaining;
    logic [WIDTH:0] w_remaining_next;
    logic           r_err;
    logic           w_err_next;
    logic [WIDTH:0] w_load_ext;
    logic           w_over;
    logic [WIDTH:0] w_clamped;
    logic           r_initstate = 1'b1;

    // Load value widened to WIDTH+1 bits so the LIMIT compare cannot wrap
    assign w_load_ext = {1'b0, load_count};
    assign w_over     = w_load_ext > (WIDTH+1)'(LIMIT);
    assign w_clamped  = (WIDTH+1)'(clamp_count(32'(w_load_ext), LIMIT));

    // State, down-counter and sticky error register; reset dominates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_err       <= w_err_next;
        end
    end

    // Next-state, next-count and error update
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_err_next       = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_remaining_next = w_clamped;
                    if (w_over) begin
                        w_err_next = 1'b1;
                    end
                    w_state_next = (w_clamped != '0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (tok_ready) begin
                    w_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == (WIDTH+1)'(1)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_remaining_next = '0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state
    assign load_ready = (r_state == ST_IDLE);
    assign tok_valid  = (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign remaining  = r_remaining;
    assign err        = r_err;

    // Marks the first cycle so checks ignore power-up contents
    always_ff @(posedge clk) begin
        r_initstate <= 1'b0;
    end

    // Inline safety properties on the registered outputs
    always_comb begin
        if (!r_initstate) begin
            assert (remaining <= (WIDTH+1)'(LIMIT));
            assert (!tok_valid || (remaining != '0));
            assert (!done || (remaining == '0));
            assert (!load_ready || !busy);
            assert ($onehot0({load_ready, tok_valid, done}));
        end
    end

endmodule

// File: tb/tb_count_drain.sv
// Directed self-checking bench for count_drain.
module tb_count_drain;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_count;
    logic             tok_valid;
    logic             tok_ready;
    logic [WIDTH:0]   remaining;
    logic             busy;
    logic             done;
    logic             err;

    int unsigned n_checks   = 0;
    int unsigned n_failures = 0;

    count_drain #(
        .WIDTH (WIDTH),
        .LIMIT (5)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_count (load_count),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock edge; outputs sampled on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input int unsigned exp_err);
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_tok_valid"}, tok_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_remaining"}, remaining, 0);
        check({tag, "_err"}, err, exp_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned toks;
        int unsigned exp_rem;
        bit          seen_done;
        int unsigned pat [7];

        rst        = 1'b0;
        load_valid = 1'b0;
        load_count = '0;
        tok_ready  = 1'b0;
        @(negedge clk);

        // 1. count 3, ready high: remaining 3,2,1 then done
        do_reset();
        check_idle("rst", 0);
        load_valid = 1'b1;
        load_count = 8'd3;
        tok_ready  = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            check("t1_tok_valid", tok_valid, 1);
            check("t1_remaining", remaining, i);
            check("t1_done_low", done, 0);
            step();
        end
        check("t1_done", done, 1);
        check("t1_tok_valid_done", tok_valid, 0);
        check("t1_load_ready_done", load_ready, 0);
        step();
        check_idle("t1_end", 0);

        // 2. zero load: done straight after acceptance
        load_valid = 1'b1;
        load_count = 8'd0;
        step();
        load_valid = 1'b0;
        check("t2_done", done, 1);
        check("t2_tok_valid", tok_valid, 0);
        check("t2_busy", busy, 1);
        check("t2_err", err, 0);
        step();
        check_idle("t2_end", 0);

        // 3. over-limit load is clamped to 5 and flags err
        load_valid = 1'b1;
        load_count = 8'd9;
        step();
        load_valid = 1'b0;
        check("t3_remaining", remaining, 5);
        check("t3_err", err, 1);
        toks      = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            if (done) seen_done = 1'b1;
            else begin
                if (tok_valid && tok_ready) toks++;
                step();
            end
        end
        check("t3_done_seen", seen_done, 1);
        check("t3_tokens", toks, 5);
        check("t3_err_at_done", err, 1);
        step();
        check_idle("t3_end", 1);
        step();
        check("t3_err_sticky", err, 1);

        // 4. backpressure pattern: remaining holds whenever tok_ready is low
        do_reset();
        check_idle("t4_rst", 0);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        load_valid = 1'b1;
        load_count = 8'd4;
        step();
        load_valid = 1'b0;
        exp_rem = 4;
        toks    = 0;
        for (int i = 0; i < 7; i++) begin
            tok_ready = pat[i][0];
            check("t4_tok_valid", tok_valid, 1);
            check("t4_remaining", remaining, exp_rem);
            if (tok_valid && tok_ready) toks++;
            if (pat[i] == 1) exp_rem--;
            step();
        end
        check("t4_tokens", toks, 4);
        check("t4_done", done, 1);
        check("t4_remaining_end", remaining, 0);
        tok_ready = 1'b1;
        step();
        check_idle("t4_end", 0);

        // 5. reset mid-drain after two of five tokens
        load_valid = 1'b1;
        load_count = 8'd5;
        step();
        load_valid = 1'b0;
        step();
        step();
        check("t5_remaining_pre", remaining, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_rst", 0);
        step();
        check("t5_no_done", done, 0);
        check("t5_idle", load_ready, 1);

        // 6. load_valid held high: accepted only in IDLE, period of 4 cycles
        load_valid = 1'b1;
        load_count = 8'd2;
        toks = 0;
        for (int i = 0; i < 8; i++) begin
            check("t6_load_ready", load_ready, (i % 4 == 0) ? 1 : 0);
            check("t6_done", done, (i % 4 == 3) ? 1 : 0);
            if (tok_valid && tok_ready) toks++;
            step();
        end
        load_valid = 1'b0;
        check("t6_tokens", toks, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
